// File: rtl/addernet_tile_sched.sv
// Tile scheduler for the AdderNet adder-tree datapath: issues feature/weight reads,
// tags each read through the datapath latency and accumulates tiles into output sums.
module addernet_tile_sched #(
    parameter int RW    = 16,
    parameter int ACC_W = 24,
    parameter int AW    = 12,
    parameter int CW    = 8,
    parameter int LAT   = 3
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CW-1:0]    cmd_ntile,
    input  logic [CW-1:0]    cmd_nout,
    input  logic [AW-1:0]    cmd_if_base,
    input  logic [AW-1:0]    cmd_w_base,
    output logic             rd_en,
    output logic [AW-1:0]    if_addr,
    output logic [AW-1:0]    w_addr,
    input  logic [RW-1:0]    dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int ACC_W1 = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nx;

    logic [CW-1:0] ntile_q, nout_q, tile_cnt, out_cnt;
    logic [AW-1:0] if_base_q, w_base_q, offset;

    logic [LAT-1:0] vld_p, first_p, last_p;
    logic [ACC_W-1:0] acc_p, tap_sum;

    logic [ACC_W-1:0] fifo_mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_cnt, inflight;

    logic first_tile, last_tile, last_out, credit_ok, push, pop, accept;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [RW-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + ACC_W1'(b);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    assign first_tile = (tile_cnt == '0);
    assign last_tile  = (tile_cnt == ntile_q - CW'(1));
    assign last_out   = (out_cnt == nout_q - CW'(1));
    // An output holds a credit from its first-tile issue until it leaves the FIFO.
    assign credit_ok  = ({1'b0, fifo_cnt} + {1'b0, inflight}) < 3'd2;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;

    assign if_addr = if_base_q + offset;
    assign w_addr  = w_base_q + AW'(tile_cnt);

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ntile == '0 || cmd_nout == '0)
                        state_nx = DRAIN;
                    else
                        state_nx = ISSUE;
                end
            end
            ISSUE: begin
                rd_en = !first_tile || credit_ok;
                if (rd_en && last_tile && last_out)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (vld_p == '0 && fifo_cnt == '0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            ntile_q   <= '0;
            nout_q    <= '0;
            if_base_q <= '0;
            w_base_q  <= '0;
            tile_cnt  <= '0;
            out_cnt   <= '0;
            offset    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ntile_q   <= cmd_ntile;
                nout_q    <= cmd_nout;
                if_base_q <= cmd_if_base;
                w_base_q  <= cmd_w_base;
                tile_cnt  <= '0;
                out_cnt   <= '0;
                offset    <= '0;
            end else if (rd_en) begin
                offset <= offset + AW'(1);
                if (last_tile) begin
                    tile_cnt <= '0;
                    out_cnt  <= out_cnt + CW'(1);
                end else begin
                    tile_cnt <= tile_cnt + CW'(1);
                end
            end
        end
    end

    // Tag pipeline: index LAT-1 lines up with the dp_result of the tagged read.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_p   <= '0;
            first_p <= '0;
            last_p  <= '0;
        end else begin
            vld_p   <= (vld_p << 1) | LAT'(rd_en);
            first_p <= (first_p << 1) | LAT'(rd_en & first_tile);
            last_p  <= (last_p << 1) | LAT'(rd_en & last_tile);
        end
    end

    // Accumulate stage
    assign tap_sum = first_p[LAT-1] ? ACC_W'(dp_result) : sat_add(acc_p, dp_result);
    assign push    = vld_p[LAT-1] & last_p[LAT-1];

    always_ff @(posedge CLK) begin
        if (vld_p[LAT-1])
            acc_p <= tap_sum;
    end

    // Output FIFO, first-word fall-through
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_mem[rd_ptr];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
            inflight    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= tap_sum;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            inflight <= inflight + {1'b0, rd_en & first_tile} - {1'b0, push};
        end
    end

endmodule
